// File: rtl/activate_pkg.sv
// Shared types and helpers for the activation sequencers.
package activate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/tanh_seq_tanh.sv
// Combinational fixed-point tanh: odd-symmetric piecewise-linear fit on |x|
// with FRAC fractional bits, saturating to +/-1.0 from |x| >= 3.0.
module Tanh #(
  parameter int BW_IN  = 32,
  parameter int BW_OUT = 32,
  parameter int FRAC   = 16
) (
  input  logic [BW_IN-1:0]  x_i,
  output logic [BW_OUT-1:0] y_o
);

  localparam logic [BW_IN-1:0] ONE    = BW_IN'(1) << FRAC;
  localparam logic [BW_IN-1:0] HALF   = ONE >> 1;
  localparam logic [BW_IN-1:0] TWO    = ONE << 1;
  localparam logic [BW_IN-1:0] THREE  = ONE + TWO;
  localparam logic [BW_IN-1:0] C_025  = ONE >> 2;
  localparam logic [BW_IN-1:0] C_0625 = (ONE >> 1) + (ONE >> 3);
  localparam logic [BW_IN-1:0] C_075  = (ONE >> 1) + (ONE >> 2);

  logic             neg;
  logic [BW_IN-1:0] mag;
  logic [BW_IN-1:0] ymag;
  logic [BW_IN-1:0] y_s;

  // Unsigned magnitude: the most negative input maps cleanly to 2^(BW_IN-1).
  always_comb begin
    neg = x_i[BW_IN-1];
    mag = neg ? (~x_i + BW_IN'(1)) : x_i;
    if (mag < HALF)       ymag = mag;
    else if (mag < ONE)   ymag = (mag >> 1) + C_025;
    else if (mag < TWO)   ymag = (mag >> 3) + C_0625;
    else if (mag < THREE) ymag = (mag >> 4) + C_075;
    else                  ymag = ONE;
    y_s = neg ? (~ymag + BW_IN'(1)) : ymag;
  end

  if (BW_OUT == BW_IN) begin : g_same
    assign y_o = y_s;
  end else if (BW_OUT < BW_IN) begin : g_trunc
    assign y_o = y_s[BW_OUT-1:0];
  end else begin : g_sext
    assign y_o = {{(BW_OUT-BW_IN){y_s[BW_IN-1]}}, y_s};
  end

endmodule

// File: rtl/tanh_seq.sv
// Time-multiplexed vector tanh: LANES shared Tanh units walk the input vector
// one group per cycle; the packed result is held until downstream takes it.
//   state | meaning
//   IDLE  | waiting for a vector, in_ready high
//   RUN   | group grp goes through the Tanh lanes, results land in out_reg
//   DONE  | result_bus valid and stable until out_ready
module tanh_seq
  import activate_pkg::*;
#(
  parameter int INPUT_SIZE = 20,
  parameter int BW_IN      = 32,
  parameter int BW_OUT     = 32,
  parameter int LANES      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_SIZE*BW_IN-1:0]  vector_bus,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INPUT_SIZE*BW_OUT-1:0] result_bus,
  output logic                         busy
);

  localparam int NUM_GROUPS = ceil_div(INPUT_SIZE, LANES);
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NUM_GROUPS - 1);

  state_t                       state_q, state_d;
  logic [GW-1:0]                grp_q, grp_d;
  logic [INPUT_SIZE*BW_IN-1:0]  in_reg_q, in_reg_d;
  logic [INPUT_SIZE*BW_OUT-1:0] out_reg_q, out_reg_d;
  logic [INPUT_SIZE*BW_OUT-1:0] out_wb;
  logic [LANES-1:0][BW_IN-1:0]  lane_x;
  logic [LANES-1:0][BW_OUT-1:0] lane_y;
  logic                         last_grp;

  assign last_grp = (grp_q == LAST_GRP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      in_reg_q  <= '0;
      out_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      in_reg_q  <= in_reg_d;
      out_reg_q <= out_reg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_grp)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grp_d     = grp_q;
    in_reg_d  = in_reg_q;
    out_reg_d = out_reg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_reg_d = vector_bus;
          grp_d    = '0;
        end
      end
      RUN: begin
        out_reg_d = out_wb;
        grp_d     = last_grp ? '0 : grp_q + GW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign result_bus = out_reg_q;

  // Lane k sees element grp*LANES+k; lanes past the end of the vector get 0.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [NUM_GROUPS-1:0][BW_IN-1:0] cand;
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_cand
      localparam int E = g * LANES + k;
      if (E < INPUT_SIZE) begin : g_live
        assign cand[g] = in_reg_q[(INPUT_SIZE-1-E)*BW_IN +: BW_IN];
      end else begin : g_pad
        assign cand[g] = '0;
      end
    end
    assign lane_x[k] = cand[grp_q];

    Tanh #(
      .BW_IN (BW_IN),
      .BW_OUT(BW_OUT)
    ) u_tanh (
      .x_i(lane_x[k]),
      .y_o(lane_y[k])
    );
  end

  // Each result slot has exactly one (group, lane) owner, so padding lanes never write.
  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_wb
    localparam int G = i / LANES;
    localparam int K = i % LANES;
    assign out_wb[(INPUT_SIZE-1-i)*BW_OUT +: BW_OUT] =
      (grp_q == GW'(G)) ? lane_y[K] : out_reg_q[(INPUT_SIZE-1-i)*BW_OUT +: BW_OUT];
  end

endmodule

// File: tb/tb_tanh_seq.sv
// Bench for tanh_seq: two instances (LANES=4 and LANES=3) checked against a
// real-valued tanh approximation model.
module tb_tanh_seq;

  localparam int IS  = 20;
  localparam int BW  = 32;
  localparam int W   = IS * BW;
  localparam int TMO = 60;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [2];
  logic         out_ready [2];
  logic [W-1:0] vec       [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         busy      [2];
  logic [W-1:0] res       [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tanh_seq #(.INPUT_SIZE(IS), .BW_IN(BW), .BW_OUT(BW), .LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .vector_bus(vec[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result_bus(res[0]), .busy(busy[0])
  );

  tanh_seq #(.INPUT_SIZE(IS), .BW_IN(BW), .BW_OUT(BW), .LANES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .vector_bus(vec[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result_bus(res[1]), .busy(busy[1])
  );

  // ceil(20/4) and ceil(20/3)
  function automatic int ng(input int d);
    return (d == 0) ? 5 : 7;
  endfunction

  // Piecewise tanh fit on |x| in Q16 real arithmetic, odd-symmetric, floor to Q16.
  function automatic logic [BW-1:0] tanh_ref(input logic [BW-1:0] x);
    longint v, yi;
    real    r, y;
    v = longint'($signed(x));
    r = ((v < 0) ? -v : v) / 65536.0;
    if (r < 0.5)      y = r;
    else if (r < 1.0) y = r / 2.0 + 0.25;
    else if (r < 2.0) y = r / 8.0 + 0.625;
    else if (r < 3.0) y = r / 16.0 + 0.75;
    else              y = 1.0;
    yi = longint'($floor(y * 65536.0));
    if (v < 0) yi = -yi;
    return yi[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] elem(input logic [W-1:0] v, input int i);
    return BW'(v >> ((IS - 1 - i) * BW));
  endfunction

  function automatic logic [W-1:0] expect_vec(input logic [W-1:0] v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < IS; i++) r = (r << BW) | W'(tanh_ref(elem(v, i)));
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_elem();
    int s;
    if ($urandom_range(0, 3) == 0) return $urandom();
    s = int'($urandom_range(0, 458752)) - 229376;
    return BW'(s);
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r = '0;
    for (int i = 0; i < IS; i++) r = (r << BW) | W'(rand_elem());
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer v, then count cycles (accepting edge = 1) until out_valid or timeout.
  task automatic send(input int d, input logic [W-1:0] v, output int lat, output logic [W-1:0] got);
    int w = 0;
    while (!in_ready[d] && w < TMO) begin
      tick();
      w++;
    end
    in_valid[d] = 1'b1;
    vec[d] = v;
    tick();
    in_valid[d] = 1'b0;
    vec[d] = rand_vec();
    lat = 1;
    while (!out_valid[d] && lat < TMO) begin
      tick();
      lat++;
    end
    got = res[d];
  endtask

  task automatic drain(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1;
      out_ready[d] = 1'b0;
      vec[d] = rand_vec();
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (in_ready[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]);
      end
      n_cmp++;
      if (out_valid[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]);
      end
      n_cmp++;
      if (busy[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]);
      end
      n_cmp++;
      if (res[d] !== '0) begin
        n_bad++;
        $display("FAIL reset_result[%0d]: got %h want 0", d, res[d]);
      end
    end
  endtask

  task automatic test_nominal();
    int           lat;
    logic [W-1:0] got, v;
    send(0, '0, lat, got);
    n_cmp++;
    if (lat != 6) begin
      n_bad++;
      $display("FAIL nominal_zero_latency: got %0d want 6", lat);
    end
    n_cmp++;
    if (got !== expect_vec('0)) begin
      n_bad++;
      $display("FAIL nominal_zero_result: got %h want 0", got);
    end
    n_cmp++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL nominal_done_flags: got busy=%b in_ready=%b want busy=1 in_ready=0", busy[0], in_ready[0]);
    end
    drain(0);
    v = '0;
    for (int i = 0; i < IS; i++) v = (v << BW) | W'(i << 12);
    send(0, v, lat, got);
    n_cmp++;
    if (lat != 6) begin
      n_bad++;
      $display("FAIL nominal_ramp_latency: got %0d want 6", lat);
    end
    n_cmp++;
    if (got !== expect_vec(v)) begin
      n_bad++;
      $display("FAIL nominal_ramp_result: got %h want %h", got, expect_vec(v));
    end
    drain(0);
  endtask

  task automatic test_random();
    int           lat;
    logic [W-1:0] got, v;
    logic [BW-1:0] bnd [10];
    bnd = '{32'd0, 32'd32767, 32'd32768, 32'd65535, 32'd65536,
            32'd131071, 32'd131072, 32'd196607, 32'd196608, 32'h8000_0000};
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 5; n++) begin
        if (n == 0) begin
          v = '0;
          for (int i = 0; i < IS; i++)
            v = (v << BW) | W'((i < 10) ? bnd[i] : (~bnd[i-10] + 32'd1));
        end else begin
          v = rand_vec();
        end
        send(d, v, lat, got);
        n_cmp++;
        if (lat != ng(d) + 1) begin
          n_bad++;
          $display("FAIL random_latency[%0d.%0d]: got %0d want %0d", d, n, lat, ng(d) + 1);
        end
        n_cmp++;
        if (got !== expect_vec(v)) begin
          n_bad++;
          $display("FAIL random_result[%0d.%0d]: got %h want %h", d, n, got, expect_vec(v));
        end
        drain(d);
      end
    end
  endtask

  task automatic test_partial();
    int           lat;
    logic [W-1:0] got, v;
    v = rand_vec();
    send(1, v, lat, got);
    n_cmp++;
    if (lat != 8) begin
      n_bad++;
      $display("FAIL partial_latency: got %0d want 8", lat);
    end
    n_cmp++;
    if (elem(got, 18) !== tanh_ref(elem(v, 18))) begin
      n_bad++;
      $display("FAIL partial_elem18: got %h want %h", elem(got, 18), tanh_ref(elem(v, 18)));
    end
    n_cmp++;
    if (elem(got, 19) !== tanh_ref(elem(v, 19))) begin
      n_bad++;
      $display("FAIL partial_elem19: got %h want %h", elem(got, 19), tanh_ref(elem(v, 19)));
    end
    n_cmp++;
    if ($isunknown(got)) begin
      n_bad++;
      $display("FAIL partial_no_x: got %h want no X", got);
    end
    drain(1);
  endtask

  task automatic test_backpressure();
    int           lat;
    logic [W-1:0] got, v, exp_v;
    v = rand_vec();
    exp_v = expect_vec(v);
    send(0, v, lat, got);
    for (int j = 0; j < 10; j++) begin
      if (j == 3) begin
        in_valid[0] = 1'b1;
        vec[0] = rand_vec();
      end
      if (j == 4) in_valid[0] = 1'b0;
      n_cmp++;
      if (out_valid[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_out_valid[%0d]: got %b want 1", j, out_valid[0]);
      end
      n_cmp++;
      if (res[0] !== exp_v) begin
        n_bad++;
        $display("FAIL bp_result[%0d]: got %h want %h", j, res[0], exp_v);
      end
      n_cmp++;
      if (in_ready[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", j, in_ready[0]);
      end
      tick();
    end
    in_valid[0] = 1'b0;
    drain(0);
    n_cmp++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
               out_valid[0], in_ready[0], busy[0]);
    end
  endtask

  task automatic test_back_to_back(input int d);
    logic [W-1:0] v [3];
    logic [W-1:0] e [3];
    int acc_cnt = 0, out_cnt = 0, cyc = 0, last_acc = 0;
    logic will_acc, will_out;
    for (int n = 0; n < 3; n++) begin
      v[n] = rand_vec();
      e[n] = expect_vec(v[n]);
    end
    out_ready[d] = 1'b1;
    in_valid[d] = 1'b1;
    vec[d] = v[0];
    while (out_cnt < 3 && cyc < 150) begin
      will_acc = in_ready[d] && in_valid[d];
      will_out = out_valid[d] && out_ready[d];
      if (will_out) begin
        n_cmp++;
        if (res[d] !== e[out_cnt]) begin
          n_bad++;
          $display("FAIL b2b_result[%0d.%0d]: got %h want %h", d, out_cnt, res[d], e[out_cnt]);
        end
        out_cnt++;
      end
      tick();
      cyc++;
      if (will_acc) begin
        if (acc_cnt > 0) begin
          n_cmp++;
          if (cyc - last_acc != ng(d) + 2) begin
            n_bad++;
            $display("FAIL b2b_spacing[%0d.%0d]: got %0d want %0d", d, acc_cnt, cyc - last_acc, ng(d) + 2);
          end
        end
        last_acc = cyc;
        acc_cnt++;
        if (acc_cnt == 3) in_valid[d] = 1'b0;
        else vec[d] = v[acc_cnt];
      end
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b0;
    n_cmp++;
    if (out_cnt != 3) begin
      n_bad++;
      $display("FAIL b2b_count[%0d]: got %0d outputs want 3", d, out_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int           lat;
    logic [W-1:0] got, v;
    logic         seen = 1'b0;
    in_valid[0] = 1'b1;
    vec[0] = rand_vec();
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset_state: got in_ready=%b busy=%b out_valid=%b want 1 0 0",
               in_ready[0], busy[0], out_valid[0]);
    end
    n_cmp++;
    if (res[0] !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset_result: got %h want 0", res[0]);
    end
    for (int j = 0; j < 12; j++) begin
      tick();
      if (out_valid[0] === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_no_output: got out_valid seen=%b want 0", seen);
    end
    v = rand_vec();
    send(0, v, lat, got);
    n_cmp++;
    if (lat != 6) begin
      n_bad++;
      $display("FAIL midrun_next_latency: got %0d want 6", lat);
    end
    n_cmp++;
    if (got !== expect_vec(v)) begin
      n_bad++;
      $display("FAIL midrun_next_result: got %h want %h", got, expect_vec(v));
    end
    drain(0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_partial();
    test_backpressure();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
